// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester handshakes and the RAM port for mem_port_arbiter.
// slave is the arbiter side, master is the requester/RAM side.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ack;
  logic [DATA_W-1:0] if_rdata;

  logic              ls_req;
  logic              ls_we;
  logic [ADDR_W-1:0] ls_addr;
  logic [DATA_W-1:0] ls_wdata;
  logic              ls_ack;
  logic [DATA_W-1:0] ls_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              busy;

  modport slave (
    input  if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, mem_rdata,
    output if_ack, if_rdata, ls_ack, ls_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, busy
  );

  modport master (
    output if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, mem_rdata,
    input  if_ack, if_rdata, ls_ack, ls_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates the fetch (IF) and load/store (LS) paths onto one synchronous RAM port.
// Every output is a register loaded from next-state values computed in one comb block.
module mem_port_arbiter #(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 16,
  parameter int READ_LATENCY = 1,
  parameter int FIXED_PRIO   = 0
) (
  input logic               clk,
  input logic               reset,
  mem_port_arbiter_if.slave bus
);

  localparam int CNT_W = 2;

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_DONE} state_t;

  state_t            state_q, state_n;
  logic              grant_ls_q, grant_ls_n;
  logic              last_ls_q, last_ls_n;
  logic [CNT_W-1:0]  cnt_q, cnt_n;
  logic              mem_en_q, mem_en_n;
  logic              mem_we_q, mem_we_n;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_n;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_n;
  logic              if_ack_q, if_ack_n;
  logic              ls_ack_q, ls_ack_n;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_n;
  logic [DATA_W-1:0] ls_rdata_q, ls_rdata_n;
  logic              busy_q, busy_n;
  logic              pick_ls;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      grant_ls_q  <= 1'b0;
      last_ls_q   <= 1'b0;
      cnt_q       <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_ack_q    <= 1'b0;
      ls_ack_q    <= 1'b0;
      if_rdata_q  <= '0;
      ls_rdata_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_n;
      grant_ls_q  <= grant_ls_n;
      last_ls_q   <= last_ls_n;
      cnt_q       <= cnt_n;
      mem_en_q    <= mem_en_n;
      mem_we_q    <= mem_we_n;
      mem_addr_q  <= mem_addr_n;
      mem_wdata_q <= mem_wdata_n;
      if_ack_q    <= if_ack_n;
      ls_ack_q    <= ls_ack_n;
      if_rdata_q  <= if_rdata_n;
      ls_rdata_q  <= ls_rdata_n;
      busy_q      <= busy_n;
    end
  end

  // On contention LS wins if fixed priority, or if IF had the previous grant.
  assign pick_ls = bus.ls_req && (!bus.if_req || (FIXED_PRIO != 0) || !last_ls_q);

  always_comb begin
    state_n     = state_q;
    grant_ls_n  = grant_ls_q;
    last_ls_n   = last_ls_q;
    cnt_n       = cnt_q;
    mem_en_n    = mem_en_q;
    mem_we_n    = mem_we_q;
    mem_addr_n  = mem_addr_q;
    mem_wdata_n = mem_wdata_q;
    if_ack_n    = 1'b0;
    ls_ack_n    = 1'b0;
    if_rdata_n  = if_rdata_q;
    ls_rdata_n  = ls_rdata_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.if_req || bus.ls_req) begin
          grant_ls_n  = pick_ls;
          last_ls_n   = pick_ls;
          mem_en_n    = 1'b1;
          mem_we_n    = pick_ls && bus.ls_we;
          mem_addr_n  = pick_ls ? bus.ls_addr : bus.if_addr;
          mem_wdata_n = pick_ls ? bus.ls_wdata : '0;
          state_n     = S_ACCESS;
        end
      end
      S_ACCESS: begin
        mem_en_n = 1'b0;
        mem_we_n = 1'b0;
        if (mem_we_q) begin
          ls_ack_n = grant_ls_q;
          if_ack_n = !grant_ls_q;
          state_n  = S_DONE;
        end else begin
          cnt_n   = CNT_W'(READ_LATENCY - 1);
          state_n = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          if (grant_ls_q) ls_rdata_n = bus.mem_rdata;
          else            if_rdata_n = bus.mem_rdata;
          ls_ack_n = grant_ls_q;
          if_ack_n = !grant_ls_q;
          state_n  = S_DONE;
        end else begin
          cnt_n = cnt_q - CNT_W'(1);
        end
      end
      S_DONE: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase

    busy_n = (state_n != S_IDLE);
  end

  assign bus.if_ack    = if_ack_q;
  assign bus.ls_ack    = ls_ack_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.ls_rdata  = ls_rdata_q;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.busy      = busy_q;

endmodule
